// File: rtl/lsu_mmio_ctrl.sv
// ============================================================================
// Module  : lsu_mmio_ctrl
// Brief   : Multi-cycle load/store unit driving one MMIO/data bus transaction
//           per request. Optional bus watchdog enabled by LSU_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mmio_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        access_err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_misaligned;
    logic        r_access_err;

    logic        w_req_mis;
    logic        w_req_ill;
    logic        w_timeout;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep;
    logic        w_in_req;

    // Request checks use the live inputs so a faulty access skips the bus.
    assign w_req_mis = ((funct3[1:0] == 2'b01) & addr[0]) |
                       ((funct3[1:0] == 2'b10) & (|addr[1:0]));
    assign w_req_ill = is_store ? (funct3 > 3'b010)
                                : ((funct3 == 3'b011) | (funct3[2:1] == 2'b11));

`ifdef LSU_TIMEOUT_EN
    localparam int c_cnt_w = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [c_cnt_w-1:0] r_cnt;

    assign w_timeout = ((r_state == S_REQ) || (r_state == S_WAIT)) &&
                       (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= '0;
        end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    // Parameter retained so both builds share one instantiation footprint.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    assign w_shifted = bus_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load_data = w_shifted;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_data = {24'h0, w_shifted[7:0]};
            3'b101:  w_load_data = {16'h0, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    always_comb begin
        w_be        = 4'b1111;
        w_wdata_rep = r_wdata;
        if (r_is_store) begin
            case (r_funct3[1:0])
                2'b00: begin
                    w_be        = 4'b0001 << r_addr[1:0];
                    w_wdata_rep = {4{r_wdata[7:0]}};
                end
                2'b01: begin
                    w_be        = 4'b0011 << r_addr[1:0];
                    w_wdata_rep = {2{r_wdata[15:0]}};
                end
                default: begin
                    w_be        = 4'b1111;
                    w_wdata_rep = r_wdata;
                end
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (req_valid) w_next = (w_req_mis | w_req_ill) ? S_RESP : S_REQ;
            S_REQ: begin
                if (w_timeout)      w_next = S_RESP;
                else if (bus_ready) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus_rvalid)     w_next = S_RESP;
                else if (w_timeout) w_next = S_RESP;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_store   <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_rdata      <= 32'h0;
            r_misaligned <= 1'b0;
            r_access_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_is_store   <= is_store;
                    r_funct3     <= funct3;
                    r_addr       <= addr;
                    r_wdata      <= wdata;
                    r_rdata      <= 32'h0;
                    r_misaligned <= w_req_mis;
                    r_access_err <= w_req_ill;
                end
                S_REQ: if (w_timeout) r_access_err <= 1'b1;
                S_WAIT: begin
                    if (bus_rvalid) begin
                        r_access_err <= bus_err;
                        r_rdata      <= (bus_err | r_is_store) ? 32'h0 : w_load_data;
                    end else if (w_timeout) begin
                        r_access_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus and response outputs are gated by state so reset clears them at once.
    assign w_in_req   = (r_state == S_REQ);
    assign bus_valid  = w_in_req;
    assign bus_we     = w_in_req & r_is_store;
    assign bus_addr   = w_in_req ? {r_addr[31:2], 2'b00} : 32'h0;
    assign bus_be     = w_in_req ? w_be : 4'b0000;
    assign bus_wdata  = (w_in_req & r_is_store) ? w_wdata_rep : 32'h0;

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign rdata      = resp_valid ? r_rdata : 32'h0;
    assign misaligned = resp_valid & r_misaligned;
    assign access_err = resp_valid & r_access_err;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mmio_ctrl.sv
// ============================================================================
// Module  : tb_lsu_mmio_ctrl
// Brief   : Vector-table and directed-sequence bench for lsu_mmio_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, is_store, bus_ready, bus_rvalid, bus_err;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, bus_rdata;
    logic        req_ready, busy, resp_valid, misaligned, access_err;
    logic        bus_valid, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    int n_applied = 0;
    int n_fail    = 0;

    lsu_mmio_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
        .busy(busy), .resp_valid(resp_valid), .rdata(rdata),
        .misaligned(misaligned), .access_err(access_err),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brdata;
        logic        berr;
        logic        exp_bus;
        logic [31:0] exp_baddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_bwdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd);
        is_store  = st;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        req_valid = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        bit saw_bus = 0;
        bit got = 0;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        drive_req(v.st, v.f3, v.addr, v.wdata);
        bus_ready  = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = v.brdata;
        bus_err    = v.berr;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (bus_valid && !saw_bus) begin
                saw_bus = 1;
                chk("bus_addr", bus_addr, v.exp_baddr);
                chk("bus_be", {28'h0, bus_be}, {28'h0, v.exp_be});
                chk("bus_we", {31'h0, bus_we}, {31'h0, v.st});
                if (v.st) chk("bus_wdata", bus_wdata, v.exp_bwdata);
            end
            if (resp_valid) begin
                got = 1;
                chk("latency", c, v.exp_lat);
                chk("rdata", rdata, v.exp_rdata);
                chk("misaligned", {31'h0, misaligned}, {31'h0, v.exp_mis});
                chk("access_err", {31'h0, access_err}, {31'h0, v.exp_err});
            end
        end
        if (!got) chk("resp_wait_bound", 0, 1);
        chk("bus_used", {31'h0, saw_bus}, {31'h0, v.exp_bus});
        bus_rvalid = 1'b0;
        bus_err    = 1'b0;
        @(negedge clk);
        chk("resp_one_cycle", {31'h0, resp_valid}, 0);
        chk("req_ready_after", {31'h0, req_ready}, 1);
    endtask

    initial begin
        int cnt;
        bit got;
        //          st f3      addr          wdata         brdata        be  bus baddr        be    bwdata        rdata         mis err lat
        vt[0]  = '{0, 3'b000, 32'h0000_1003, 32'h0,        32'h80AA_BBCC, 0, 1, 32'h0000_1000, 4'hF, 32'h0,        32'hFFFF_FF80, 0, 0, 3};
        vt[1]  = '{0, 3'b101, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 0, 1, 32'h0000_2000, 4'hF, 32'h0,        32'h0000_BEEF, 0, 0, 3};
        vt[2]  = '{1, 3'b001, 32'h0000_2002, 32'h0000_5678, 32'hFFFF_FFFF, 0, 1, 32'h0000_2000, 4'hC, 32'h5678_5678, 32'h0,        0, 0, 3};
        vt[3]  = '{0, 3'b010, 32'h0000_0006, 32'h0,        32'h1111_1111, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        1, 0, 1};
        vt[4]  = '{0, 3'b011, 32'h0000_0010, 32'h0,        32'h0,        0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        0, 1, 1};
        vt[5]  = '{0, 3'b000, 32'h0000_1001, 32'h0,        32'h1234_5678, 0, 1, 32'h0000_1000, 4'hF, 32'h0,        32'h0000_0056, 0, 0, 3};
        vt[6]  = '{0, 3'b001, 32'h0000_1000, 32'h0,        32'h1234_8001, 0, 1, 32'h0000_1000, 4'hF, 32'h0,        32'hFFFF_8001, 0, 0, 3};
        vt[7]  = '{0, 3'b100, 32'h0000_3002, 32'h0,        32'h00C3_0000, 0, 1, 32'h0000_3000, 4'hF, 32'h0,        32'h0000_00C3, 0, 0, 3};
        vt[8]  = '{0, 3'b010, 32'h0000_0004, 32'h0,        32'hDEAD_BEEF, 0, 1, 32'h0000_0004, 4'hF, 32'h0,        32'hDEAD_BEEF, 0, 0, 3};
        vt[9]  = '{1, 3'b000, 32'h0000_0007, 32'h1234_56AB, 32'h0,        0, 1, 32'h0000_0004, 4'h8, 32'hABAB_ABAB, 32'h0,        0, 0, 3};
        vt[10] = '{1, 3'b010, 32'h0000_0008, 32'hCAFE_F00D, 32'h0,        0, 1, 32'h0000_0008, 4'hF, 32'hCAFE_F00D, 32'h0,        0, 0, 3};
        vt[11] = '{1, 3'b001, 32'h0000_0001, 32'h0000_1234, 32'h0,        0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        1, 0, 1};
        vt[12] = '{1, 3'b100, 32'h0000_0000, 32'h0000_00FF, 32'h0,        0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        0, 1, 1};
        vt[13] = '{0, 3'b000, 32'h0000_2000, 32'h0,        32'h0000_007F, 1, 1, 32'h0000_2000, 4'hF, 32'h0,        32'h0,        0, 1, 3};
        vt[14] = '{0, 3'b101, 32'h0000_0002, 32'h0,        32'h8000_0000, 0, 1, 32'h0000_0000, 4'hF, 32'h0,        32'h0000_8000, 0, 0, 3};
        vt[15] = '{0, 3'b001, 32'h0000_0002, 32'h0,        32'h8000_0000, 0, 1, 32'h0000_0000, 4'hF, 32'h0,        32'hFFFF_8000, 0, 0, 3};

        rst_n = 1'b0; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; bus_ready = 1'b0; bus_rvalid = 1'b0;
        bus_rdata = 32'h0; bus_err = 1'b0;
        #1;
        chk("rst_req_ready", {31'h0, req_ready}, 1);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_bus_valid", {31'h0, bus_valid}, 0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 0);
        chk("rst_bus_be_addr", {bus_addr[27:0], bus_be}, 0);
        chk("rst_rdata", rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(vt[i]);

        // SW with bus_ready held low for three cycles, completed by a bus error
        @(negedge clk);
        drive_req(1'b1, 3'b010, 32'h0000_0040, 32'hA5A5_0F0F);
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stall_bus_valid", {31'h0, bus_valid}, 1);
            chk("stall_bus_addr", bus_addr, 32'h0000_0040);
            chk("stall_bus_be", {28'h0, bus_be}, 32'hF);
            chk("stall_bus_wdata", bus_wdata, 32'hA5A5_0F0F);
            if (k == 3) bus_ready = 1'b1;
        end
        @(negedge clk);
        chk("stall_wait_no_bus", {31'h0, bus_valid}, 0);
        bus_ready = 1'b0; bus_rvalid = 1'b1; bus_err = 1'b1;
        @(negedge clk);
        chk("berr_resp_valid", {31'h0, resp_valid}, 1);
        chk("berr_access_err", {31'h0, access_err}, 1);
        chk("berr_rdata", rdata, 0);
        bus_rvalid = 1'b0; bus_err = 1'b0;

        // Asynchronous reset while in WAIT; late rvalid must be ignored
        @(negedge clk);
        drive_req(1'b0, 3'b010, 32'h0000_0000, 32'h0);
        bus_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rw_req_bus_valid", {31'h0, bus_valid}, 1);
        @(negedge clk);
        chk("rw_wait_busy", {31'h0, busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_busy", {31'h0, busy}, 0);
        chk("rw_bus_valid", {31'h0, bus_valid}, 0);
        chk("rw_resp_valid", {31'h0, resp_valid}, 0);
        chk("rw_req_ready", {31'h0, req_ready}, 1);
        @(negedge clk);
        rst_n = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) cnt++;
        end
        chk("rw_late_rvalid_resp", cnt, 0);
        bus_rvalid = 1'b0;

        // Asynchronous reset while in REQ drops bus_valid mid-cycle
        @(negedge clk);
        drive_req(1'b1, 3'b010, 32'h0000_0080, 32'h1);
        bus_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rr_bus_valid_before", {31'h0, bus_valid}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_bus_valid_after", {31'h0, bus_valid}, 0);
        chk("rr_bus_be_after", {28'h0, bus_be}, 0);
        @(negedge clk);
        rst_n = 1'b1; bus_ready = 1'b1;
        @(negedge clk);
        chk("rr_stays_idle", {31'h0, busy}, 0);

`ifdef LSU_TIMEOUT_EN
        // Watchdog: no rvalid, abort after 8 REQ/WAIT cycles
        @(negedge clk);
        drive_req(1'b0, 3'b010, 32'h0000_0000, 32'h0);
        bus_ready = 1'b1; bus_rvalid = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1;
                chk("to_latency", c, 9);
                chk("to_access_err", {31'h0, access_err}, 1);
                chk("to_rdata", rdata, 0);
            end
        end
        if (!got) chk("to_resp_wait_bound", 0, 1);
        @(negedge clk);
        chk("to_back_idle", {31'h0, req_ready}, 1);
        bus_rvalid = 1'b1;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) cnt++;
        end
        chk("to_late_rvalid_resp", cnt, 0);
        bus_rvalid = 1'b0;
`else
        // No watchdog: the LSU keeps waiting until rvalid arrives
        @(negedge clk);
        drive_req(1'b0, 3'b010, 32'h0000_0000, 32'h0);
        bus_ready = 1'b1; bus_rvalid = 1'b0; bus_rdata = 32'h0102_0304;
        @(posedge clk);
        #1 req_valid = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (resp_valid) cnt++;
        end
        chk("nw_no_resp", cnt, 0);
        chk("nw_busy", {31'h0, busy}, 1);
        bus_rvalid = 1'b1;
        @(negedge clk);
        chk("nw_resp_valid", {31'h0, resp_valid}, 1);
        chk("nw_rdata", rdata, 32'h0102_0304);
        bus_rvalid = 1'b0;
        @(negedge clk);
        chk("nw_back_idle", {31'h0, req_ready}, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
